// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment driver with per-slot anode blanking.
// Optional leading-zero blanking: define SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] BCD0,
  input  logic [3:0] BCD1,
  input  logic [3:0] BCD2,
  input  logic [3:0] BCD3,
  output logic [6:0] Seg,
  output logic       Dp,
  output logic [3:0] An
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_N = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    s_q, s_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    digit;
  logic          lz;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = 7'h40;
      4'd1:    r = 7'h79;
      4'd2:    r = 7'h24;
      4'd3:    r = 7'h30;
      4'd4:    r = 7'h19;
      4'd5:    r = 7'h12;
      4'd6:    r = 7'h02;
      4'd7:    r = 7'h78;
      4'd8:    r = 7'h00;
      4'd9:    r = 7'h10;
      4'd15:   r = 7'h3F;
      default: r = 7'h7F;
    endcase
    return r;
  endfunction

  assign digit = shadow_q[{s_q, 2'b00} +: 4];

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic z3, z2, z1;
  assign z3 = (shadow_q[15:12] == 4'd0);
  assign z2 = z3 && (shadow_q[11:8] == 4'd0);
  assign z1 = z2 && (shadow_q[7:4] == 4'd0);
  always_comb begin
    lz = 1'b0;
    case (s_q)
      2'd1:    lz = z1;
      2'd2:    lz = z2;
      2'd3:    lz = z3;
      default: lz = 1'b0;
    endcase
  end
`else
  assign lz = 1'b0;
`endif

  always_comb begin
    cnt_d    = cnt_q + CW'(1);
    s_d      = s_q;
    shadow_d = shadow_q;
    an_d     = 4'hF;
    seg_d    = 7'h7F;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      s_d   = s_q + 2'd1;
    end
    // Frame start: latch all digits at once so a frame never tears
    if (s_q == 2'd0 && cnt_q == '0) begin
      shadow_d = {BCD3, BCD2, BCD1, BCD0};
    end
    if (cnt_q >= BLANK_N) begin
      an_d  = ~(4'b0001 << s_q);
      seg_d = lz ? 7'h7F : decode(digit);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q    <= '0;
      s_q      <= 2'd0;
      shadow_q <= 16'h0000;
      an_q     <= 4'hF;
      seg_q    <= 7'h7F;
    end else begin
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign An  = an_q;
  assign Seg = seg_q;
  assign Dp  = 1'b1;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan at SCAN_DIV=8, BLANK_CYCLES=2.
// Follows SEVEN_SEG_LEADING_ZERO_BLANK_EN the same way as the design.
module tb_seven_seg_scan;

  localparam int SD = 8;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] b0 = '0, b1 = '0, b2 = '0, b3 = '0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  seven_seg_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .Clk(clk), .Reset(rst),
    .BCD0(b0), .BCD1(b1), .BCD2(b2), .BCD3(b3),
    .Seg(seg), .Dp(dp), .An(an)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  localparam logic [6:0] DEC [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F
  };
  localparam logic [3:0] ANS [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  exp_t        sb[$];
  int          vec = 0;
  int          err = 0;
  int          m_cnt = 0;
  int          m_s = 0;
  logic [15:0] m_sh = '0;
  int          run = 0;
  logic [6:0]  seen [4];

  function automatic logic [3:0] dig(input logic [15:0] sh, input int i);
    logic [3:0] d;
    d = sh[i*4 +: 4];
    return d;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    logic [3:0] d;
    logic blank;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    if (m_cnt >= BC) begin
      d = dig(m_sh, m_s);
      blank = 1'b0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      if (m_s > 0) begin
        blank = 1'b1;
        for (int k = m_s; k < 4; k++)
          if (dig(m_sh, k) != 4'd0) blank = 1'b0;
      end
`endif
      e.an  = ANS[m_s];
      e.seg = blank ? 7'h7F : DEC[d];
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] expv);
    vec++;
    assert (obs === expv) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic r);
    exp_t e;
    logic [15:0] inp;
    rst = r;
    inp = {b3, b2, b1, b0};
    if (r) e = '{an: 4'hF, seg: 7'h7F};
    else   e = model_out();
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (r) begin
      m_cnt = 0; m_s = 0; m_sh = '0;
    end else begin
      if (m_s == 0 && m_cnt == 0) m_sh = inp;
      if (m_cnt == SD - 1) begin
        m_cnt = 0;
        m_s = (m_s + 1) % 4;
      end else m_cnt++;
    end
    e = sb.pop_front();
    chk("an", {3'b000, an}, {3'b000, e.an});
    chk("seg", seg, e.seg);
    chk("dp", {6'd0, dp}, 7'd1);
    vec++;
    assert ($countones(~an) <= 1) else begin
      err++;
      $error("FAIL one_hot_an observed=%b expected=at most one low", an);
    end
    for (int i = 0; i < 4; i++)
      if (an === ANS[i]) seen[i] = seg;
    if (r) run = 0;
    else if (an === 4'hF) run++;
    else begin
      if (run != 0) chk("blank_len", 7'(run), 7'(BC));
      run = 0;
    end
    rst = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic clr_seen();
    for (int i = 0; i < 4; i++) seen[i] = 7'h55;
  endtask

  initial begin
    clr_seen();
    // basic scan, 3 frames
    b3 = 4'd1; b2 = 4'd2; b1 = 4'd3; b0 = 4'd4;
    step(1'b1);
    step(1'b1);
    steps(3 * 4 * SD);
    chk("scan_s0", seen[0], 7'h19);
    chk("scan_s1", seen[1], 7'h30);
    chk("scan_s2", seen[2], 7'h24);
    chk("scan_s3", seen[3], 7'h79);

    // tear-free update during slot 2
    steps(2 * SD + BC + 2);
    b0 = 4'd9;
    clr_seen();
    steps(2 * SD - BC - 2);
    chk("tear_s3_old", seen[3], 7'h79);
    chk("tear_s2_old", seen[2], 7'h24);
    steps(4 * SD);
    chk("tear_s0_new", seen[0], 7'h10);

    // overflow on every digit
    b3 = 4'hF; b2 = 4'hF; b1 = 4'hF; b0 = 4'hF;
    clr_seen();
    step(1'b1);
    steps(4 * SD + 1);
    for (int i = 0; i < 4; i++) chk("dash", seen[i], 7'h3F);

    // leading zeros
    b3 = 4'd0; b2 = 4'd0; b1 = 4'd0; b0 = 4'd7;
    clr_seen();
    step(1'b1);
    steps(4 * SD + 1);
    chk("lz_s0", seen[0], 7'h78);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    for (int i = 1; i < 4; i++) chk("lz_blank", seen[i], 7'h7F);
`else
    for (int i = 1; i < 4; i++) chk("lz_zero", seen[i], 7'h40);
`endif
    b0 = 4'd0;
    clr_seen();
    step(1'b1);
    steps(4 * SD + 1);
    chk("lz_all0_s0", seen[0], 7'h40);

    // reset pulse in slot-2 show phase
    b3 = 4'd1; b2 = 4'd2; b1 = 4'd3; b0 = 4'd4;
    step(1'b1);
    steps(2 * SD + BC + 2);
    step(1'b1);
    chk("rst_mid_seg", seg, 7'h7F);
    chk("rst_mid_an", {3'b000, an}, 7'h0F);
    clr_seen();
    steps(5 * SD);
    chk("rst_mid_s0", seen[0], 7'h19);
    chk("rst_mid_s3", seen[3], 7'h79);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles per digit slot; legal range is SCAN_DIV >= BLANK_CYCLES+2.
REQ-002 SHALL have parameter BLANK_CYCLES, default 500, meaning all-anodes-off cycles at the start of each slot; legal range is BLANK_CYCLES >= 1.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports BCD0, BCD1, BCD2, BCD3, input, 4 bits each: digit codes, BCD0 least significant; 4'hf means overflow.
REQ-006 SHALL have port Seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-007 SHALL have port Dp, output, 1 bit: decimal point, active-low, held 1 (off).
REQ-008 SHALL have port An, output, 4 bits: digit anodes, active-low, An[i] selects digit i, registered.

Function
REQ-009 SHALL keep a slot counter cnt, 0..SCAN_DIV-1, and a slot index s, 0..3.
- cnt increments every cycle.
- When cnt reaches SCAN_DIV-1, cnt wraps to 0 and s increments, with s wrapping 3->0.
REQ-010 SHALL load a 16-bit shadow register from {BCD3,BCD2,BCD1,BCD0} on every cycle where s==0 and cnt==0 (frame start).
- Input changes at any other time SHALL NOT affect the displayed value until the next frame start.
REQ-011 SHALL drive An=4'b1111 and Seg=7'h7F while cnt < BLANK_CYCLES (blank phase).
REQ-012 SHALL drive An with only bit s low, and Seg with the decoded shadow digit s, while cnt >= BLANK_CYCLES (show phase).
REQ-013 SHALL decode digits to active-low Seg as follows:
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
- 10..14 = 7F (blank).
- 15 = 3F (dash).
REQ-014 SHALL register An and Seg, so each reflects the (s,cnt) state one cycle after it is reached; latency is fixed and identical for An and Seg.
REQ-015 SHALL never drive two An bits low in the same cycle, including at slot boundaries and on reset entry or exit.
REQ-016 SHALL display 4'hf on any digit as a dash independently per digit; an all-4'hf input shows four dashes.

Reset
REQ-017 SHALL, on Reset high at a rising edge, set cnt=0, s=0, shadow=16'h0000, An=4'b1111, Seg=7'h7F and Dp=1 in the following cycle.
REQ-018 SHALL abort any slot in progress when Reset is asserted mid-frame.
REQ-019 SHALL start a new frame on the first cycle after Reset deasserts (s=0, cnt=0, shadow loaded).

Configuration
REQ-020 SHALL implement leading-zero blanking when macro SEVEN_SEG_LEADING_ZERO_BLANK_EN is defined:
- Digit i (i=3,2,1) is shown as 7F when shadow digit i and every more-significant shadow digit equal 0.
- Digit 0 is always shown.
- Code 15 is non-zero for this rule.
REQ-021 SHALL show all four digits as decoded per REQ-013, including leading zeros, when SEVEN_SEG_LEADING_ZERO_BLANK_EN is undefined.

Verification (SCAN_DIV=8, BLANK_CYCLES=2)
REQ-022 SHALL cover the basic scan: BCD3..0=1,2,3,4 after reset.
- Per slot: 2 cycles An=1111/Seg=7F, then 6 cycles of the active digit.
- Required sequence: An=1110/Seg=19, then An=1101/30, then An=1011/24, then An=0111/79, repeating.
REQ-023 SHALL cover overflow: all inputs 4'hf -> every show phase Seg=3F; no other code appears.
REQ-024 SHALL cover tear-free update: change BCD0 from 4 to 9 during slot 2.
- Slot 3 and the remainder of the frame still show the old values.
- The next frame's slot 0 shows Seg=10.
REQ-025 SHALL cover leading-zero blanking with BCD3..0=0,0,0,7:
- With the macro: slots 1-3 Seg=7F, slot 0 Seg=78.
- Without the macro: slots 1-3 Seg=40.
- With the macro and input 0,0,0,0: slot 0 Seg=40.
REQ-026 SHALL cover reset mid-frame: pulse Reset for 1 cycle during the slot-2 show phase.
- Next cycle: An=1111, Seg=7F.
- The following frame begins at slot 0 with full 2-cycle blanking.
- At no cycle are two An bits low.
REQ-027 SHALL cover the blanking interval: An=1111 for exactly 2 consecutive cycles at every slot boundary across 3 full frames.
